// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the
// direction predictor tables.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_BIMODAL    = 2'd0,
    BP_GSHARE     = 2'd1,
    BP_TOURNAMENT = 2'd2
  } bp_mode_e;

  localparam int unsigned MAX_CTR_BITS = 4;

  function automatic logic [3:0] ctr_init(
    int unsigned bits
  );
    return 4'((32'd1 << (bits - 1)) - 32'd1);
  endfunction

  function automatic logic [3:0] sat_inc(
    logic [3:0]  ctr,
    int unsigned bits
  );
    logic [3:0] top;
    top = 4'((32'd1 << bits) - 32'd1);
    return (ctr >= top) ? top : ctr + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(
    logic [3:0]  ctr,
    int unsigned bits
  );
    if (bits == 0) return 4'd0;
    return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/tournament_bht_if.sv
// Fetch lookup / branch-unit update bundle of the
// direction predictor.
interface tournament_bht_if #(
  parameter int unsigned VLEN = 64
);
  logic            lookup_valid_i;
  logic [VLEN-1:0] lookup_pc_i;
  logic            pred_valid_o;
  logic            pred_taken_o;
  logic            update_valid_i;
  logic [VLEN-1:0] update_pc_i;
  logic            update_taken_i;
  logic [31:0]     mispredict_cnt_o;

  modport master (
    output lookup_valid_i,
    output lookup_pc_i,
    input  pred_valid_o,
    input  pred_taken_o,
    output update_valid_i,
    output update_pc_i,
    output update_taken_i,
    input  mispredict_cnt_o
  );

  modport slave (
    input  lookup_valid_i,
    input  lookup_pc_i,
    output pred_valid_o,
    output pred_taken_o,
    input  update_valid_i,
    input  update_pc_i,
    input  update_taken_i,
    output mispredict_cnt_o
  );
endinterface

// File: rtl/bp_ctr_table.sv
// Table of saturating direction counters: one comb
// read port, one write port that also exposes its entry.
module bp_ctr_table
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned CTR_BITS = 2,
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_taken_o,
  input  logic          wr_valid_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic          wr_taken_i,
  output logic          wr_pred_o
);

  localparam logic [CTR_BITS-1:0] INIT =
    CTR_BITS'(ctr_init(CTR_BITS));

  logic [CTR_BITS-1:0] mem_q [DEPTH];
  logic [3:0]          cur;
  logic [CTR_BITS-1:0] nxt;

  assign cur = 4'(mem_q[wr_idx_i]);
  assign nxt = CTR_BITS'(wr_taken_i
             ? sat_inc(cur, CTR_BITS)
             : sat_dec(cur, CTR_BITS));

  assign rd_taken_o = mem_q[rd_idx_i][CTR_BITS-1];
  assign wr_pred_o  = mem_q[wr_idx_i][CTR_BITS-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= INIT;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= INIT;
    end else if (wr_valid_i) begin
      mem_q[wr_idx_i] <= nxt;
    end
  end

endmodule

// File: rtl/tournament_bht.sv
// Elaboration-selected bimodal / gshare / tournament
// branch direction predictor with mispredict counter.
module tournament_bht
  import bp_pkg::*;
#(
  parameter int unsigned VLEN               = 64,
  parameter int unsigned MODE               = 2,
  parameter int unsigned GLOBAL_ENTRIES     = 1024,
  parameter int unsigned LOCAL_HIST_ENTRIES = 1024,
  parameter int unsigned LOCAL_PRED_ENTRIES = 1024,
  parameter int unsigned CHOICE_ENTRIES     = 1024,
  parameter int unsigned GLOBAL_CTR_BITS    = 2,
  parameter int unsigned LOCAL_CTR_BITS     = 2,
  parameter int unsigned CHOICE_CTR_BITS    = 2,
  parameter int unsigned RVC                = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_bp_i,
  tournament_bht_if.slave bus
);

  localparam bp_mode_e    M  = bp_mode_e'(2'(MODE));
  localparam int unsigned A  = (RVC != 0) ? 1 : 2;
  localparam int unsigned GW = $clog2(GLOBAL_ENTRIES);
  localparam int unsigned HW = $clog2(LOCAL_HIST_ENTRIES);
  localparam int unsigned LW = $clog2(LOCAL_PRED_ENTRIES);
  localparam int unsigned CW = $clog2(CHOICE_ENTRIES);

  logic            upd;
  logic            tkn;
  logic            pv;
  logic [GW-1:0]   ghr;
  logic [GW-1:0]   lk_gidx;
  logic [GW-1:0]   up_gidx;
  logic            g_lk;
  logic            g_up;
  logic            lk_sel;
  logic            up_sel;
  logic [31:0]     mis_cnt_q;
  logic [VLEN-1:0] unused_pc;

  // Flush wins over a same-cycle update.
  assign upd = bus.update_valid_i & ~flush_bp_i;
  assign tkn = bus.update_taken_i;
  assign pv  = bus.lookup_valid_i & ~flush_bp_i;

  assign lk_gidx = bus.lookup_pc_i[A +: GW] ^ ghr;
  assign up_gidx = bus.update_pc_i[A +: GW] ^ ghr;

  assign unused_pc = bus.lookup_pc_i ^ bus.update_pc_i;

  bp_ctr_table #(
    .DEPTH    (GLOBAL_ENTRIES),
    .CTR_BITS (GLOBAL_CTR_BITS)
  ) u_global (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (flush_bp_i),
    .rd_idx_i   (lk_gidx),
    .rd_taken_o (g_lk),
    .wr_valid_i (upd),
    .wr_idx_i   (up_gidx),
    .wr_taken_i (tkn),
    .wr_pred_o  (g_up)
  );

  if (M != BP_BIMODAL) begin : g_ghr
    logic [GW-1:0] ghr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)         ghr_q <= '0;
      else if (flush_bp_i) ghr_q <= '0;
      else if (upd)        ghr_q <= GW'({ghr_q, tkn});
    end
    assign ghr = ghr_q;
  end else begin : g_no_ghr
    assign ghr = '0;
  end

  if (M == BP_TOURNAMENT) begin : g_tour
    logic [LW-1:0] lht_q [LOCAL_HIST_ENTRIES];
    logic [HW-1:0] up_hidx;
    logic [LW-1:0] lk_hist;
    logic [LW-1:0] up_hist;
    logic          l_lk;
    logic          l_up;
    logic          c_lk;
    logic          c_up;

    assign up_hidx = bus.update_pc_i[A +: HW];
    assign lk_hist = lht_q[bus.lookup_pc_i[A +: HW]];
    assign up_hist = lht_q[up_hidx];

    bp_ctr_table #(
      .DEPTH    (LOCAL_PRED_ENTRIES),
      .CTR_BITS (LOCAL_CTR_BITS)
    ) u_local (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (flush_bp_i),
      .rd_idx_i   (lk_hist),
      .rd_taken_o (l_lk),
      .wr_valid_i (upd),
      .wr_idx_i   (up_hist),
      .wr_taken_i (tkn),
      .wr_pred_o  (l_up)
    );

    // Choice only learns when the two sides disagree;
    // counting up means "trust global".
    bp_ctr_table #(
      .DEPTH    (CHOICE_ENTRIES),
      .CTR_BITS (CHOICE_CTR_BITS)
    ) u_choice (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (flush_bp_i),
      .rd_idx_i   (bus.lookup_pc_i[A +: CW]),
      .rd_taken_o (c_lk),
      .wr_valid_i (upd & (l_up != g_up)),
      .wr_idx_i   (bus.update_pc_i[A +: CW]),
      .wr_taken_i (g_up == tkn),
      .wr_pred_o  (c_up)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < LOCAL_HIST_ENTRIES; i++)
          lht_q[i] <= '0;
      end else if (flush_bp_i) begin
        for (int i = 0; i < LOCAL_HIST_ENTRIES; i++)
          lht_q[i] <= '0;
      end else if (upd) begin
        lht_q[up_hidx] <= LW'({up_hist, tkn});
      end
    end

    assign lk_sel = c_lk ? g_lk : l_lk;
    assign up_sel = c_up ? g_up : l_up;
  end else begin : g_single
    assign lk_sel = g_lk;
    assign up_sel = g_up;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      mis_cnt_q <= '0;
    else if (upd && (up_sel != tkn) && (mis_cnt_q != '1))
      mis_cnt_q <= mis_cnt_q + 32'd1;
  end

  assign bus.pred_valid_o     = pv;
  assign bus.pred_taken_o     = pv & lk_sel;
  assign bus.mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_tournament_bht.sv
// Drives bimodal, gshare and tournament instances with one
// stimulus stream and scores them against a table model.
module tb_tournament_bht;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        lv = 1'b0;
  logic        uv = 1'b0;
  logic        ut = 1'b0;
  logic [63:0] lpc = '0;
  logic [63:0] upc = '0;

  always #5 clk = ~clk;

  tournament_bht_if #(.VLEN(64)) bi (), gs (), tn ();

  assign bi.lookup_valid_i = lv;
  assign bi.lookup_pc_i    = lpc;
  assign bi.update_valid_i = uv;
  assign bi.update_pc_i    = upc;
  assign bi.update_taken_i = ut;
  assign gs.lookup_valid_i = lv;
  assign gs.lookup_pc_i    = lpc;
  assign gs.update_valid_i = uv;
  assign gs.update_pc_i    = upc;
  assign gs.update_taken_i = ut;
  assign tn.lookup_valid_i = lv;
  assign tn.lookup_pc_i    = lpc;
  assign tn.update_valid_i = uv;
  assign tn.update_pc_i    = upc;
  assign tn.update_taken_i = ut;

  tournament_bht #(.MODE(0)) u_bi (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_bp_i(flush), .bus(bi.slave));
  tournament_bht #(.MODE(1)) u_gs (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_bp_i(flush), .bus(gs.slave));
  tournament_bht #(.MODE(2)) u_tn (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_bp_i(flush), .bus(tn.slave));

  logic        pv_o [3];
  logic        pt_o [3];
  logic [31:0] mc_o [3];

  assign pv_o[0] = bi.pred_valid_o;
  assign pv_o[1] = gs.pred_valid_o;
  assign pv_o[2] = tn.pred_valid_o;
  assign pt_o[0] = bi.pred_taken_o;
  assign pt_o[1] = gs.pred_taken_o;
  assign pt_o[2] = tn.pred_taken_o;
  assign mc_o[0] = bi.mispredict_cnt_o;
  assign mc_o[1] = gs.mispredict_cnt_o;
  assign mc_o[2] = tn.mispredict_cnt_o;

  // Reference state: plain integers per table entry.
  int     g [3][N];
  int     l [N];
  int     c [N];
  int     h [N];
  int     ghr [3];
  longint cnt [3];

  typedef struct packed {
    logic             pv;
    logic [2:0]       pt;
    logic [2:0][31:0] cnt;
  } exp_t;

  exp_t q [$];
  int   vec = 0;
  int   bad = 0;

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, a, e, $time);
    end
  endtask

  function automatic int idx(logic [63:0] pc);
    return int'((pc >> 1) % N);
  endfunction

  function automatic int step(int v, bit up);
    if (up) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic void mreset(bit all);
    for (int m = 0; m < 3; m++) begin
      ghr[m] = 0;
      for (int i = 0; i < N; i++) g[m][i] = 1;
      if (all) cnt[m] = 0;
    end
    for (int i = 0; i < N; i++) begin
      l[i] = 1;
      c[i] = 1;
      h[i] = 0;
    end
  endfunction

  function automatic bit pred(int m, logic [63:0] pc);
    int i  = idx(pc);
    int gi = (m == 0) ? i : (i ^ ghr[m]);
    bit gp = g[m][gi] >= 2;
    if (m != 2) return gp;
    return (c[i] >= 2) ? gp : (l[h[i]] >= 2);
  endfunction

  function automatic void mupdate(int m, logic [63:0] pc,
                                  bit t);
    int i  = idx(pc);
    int gi = (m == 0) ? i : (i ^ ghr[m]);
    int li = h[i];
    bit gp = g[m][gi] >= 2;
    bit lp = l[li] >= 2;
    bit fin = pred(m, pc);
    if (fin != t && cnt[m] < 64'hFFFF_FFFF) cnt[m]++;
    g[m][gi] = step(g[m][gi], t);
    if (m > 0) ghr[m] = ((ghr[m] << 1) | int'(t)) % N;
    if (m == 2) begin
      l[li] = step(l[li], t);
      h[i]  = ((li << 1) | int'(t)) % N;
      if (lp != gp) c[i] = step(c[i], gp == t);
    end
  endfunction

  // One cycle of stimulus; optional spot check on mode sm.
  task automatic cyc(bit v, logic [63:0] pc, bit u,
                     logic [63:0] up, bit t, bit f = 0,
                     int sm = -1, bit spt = 0,
                     bit ck = 0, logic [31:0] scnt = 0);
    exp_t e;
    lv = v; lpc = pc; uv = u; upc = up; ut = t;
    flush = f;
    e.pv = v & ~f;
    for (int m = 0; m < 3; m++) begin
      e.pt[m]  = e.pv & pred(m, pc);
      e.cnt[m] = 32'(cnt[m]);
    end
    q.push_back(e);
    if (f) mreset(0);
    else if (u) for (int m = 0; m < 3; m++)
      mupdate(m, up, t);
    if (sm >= 0) begin
      #3;
      chk($sformatf("spot_m%0d_taken", sm),
          32'(pt_o[sm]), 32'(spt));
      if (ck)
        chk($sformatf("spot_m%0d_cnt", sm),
            mc_o[sm], scnt);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("m%0d_valid", m),
            32'(pv_o[m]), 32'(e.pv));
        chk($sformatf("m%0d_taken", m),
            32'(pt_o[m]), 32'(e.pt[m]));
        chk($sformatf("m%0d_cnt", m),
            mc_o[m], e.cnt[m]);
      end
    end
  end

  function automatic logic [63:0] rpc();
    if ($urandom_range(0, 9) == 0)
      return {$urandom, $urandom};
    return 64'h1000 + 64'($urandom_range(0, 11) * 2);
  endfunction

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    bit          t;
    mreset(1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(1, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 64'h8000_0000, 0, 0, 0, 0, 2, 0, 1, 0);

    cyc(0, 0, 1, 64'h100, 1);
    cyc(1, 64'h100, 0, 0, 0, 0, 0, 1, 1, 32'd1);
    repeat (3) cyc(0, 0, 1, 64'h100, 1);
    cyc(0, 0, 1, 64'h100, 0);
    cyc(1, 64'h100, 0, 0, 0, 0, 0, 1, 1, 32'd2);
    cyc(0, 0, 1, 64'h100, 0);
    cyc(1, 64'h100, 0, 0, 0, 0, 0, 0, 1, 32'd3);

    for (int k = 0; k < 40; k++)
      cyc(1, 64'h200, 1, 64'h200, (k % 2) == 0);

    for (int k = 0; k < 60; k++)
      cyc(1, 64'h300, 1, 64'h300, (k % 3) != 2);

    repeat (3) cyc(1, 64'h400, 1, 64'h400, 1);
    cyc(1, 64'h400, 1, 64'h400, 1, 1);
    cyc(1, 64'h400, 0, 0, 0, 0, 0, 0);
    cyc(1, 64'h400, 0, 0, 0, 0, 2, 0);

    cyc(1, 64'h500, 1, 64'h500, 1, 0, 0, 0);
    cyc(1, 64'h500, 0, 0, 0, 0, 0, 1);

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        rst_n = 1'b0;
        mreset(1);
        cyc(1, rpc(), 0, 0, 0);
        rst_n = 1'b1;
      end
      a = rpc();
      b = rpc();
      t = ($urandom_range(0, 3) != 0) ? b[3] : ~b[3];
      cyc(1'($urandom_range(0, 1)), a,
          1'($urandom_range(0, 1)), b, t,
          $urandom_range(0, 99) == 0);
    end

    cyc(0, 0, 0, 0, 0, 1);
    u_bi.mis_cnt_q = 32'hFFFF_FFFE;
    u_gs.mis_cnt_q = 32'hFFFF_FFFE;
    u_tn.mis_cnt_q = 32'hFFFF_FFFE;
    for (int m = 0; m < 3; m++) cnt[m] = 64'hFFFF_FFFE;
    cyc(1, 64'h600, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      cyc(1, 64'h600, 1, 64'h600, ~pred(0, 64'h600));
    cyc(1, 64'h600, 0, 0, 0, 0, 0, pred(0, 64'h600),
        1, 32'hFFFF_FFFF);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule

// File: doc/tournament_bht.md
Name: tournament_bht

Overview:
- Parametrised successor to the fixed 2-bit BHT in the CVA6 frontend.
- Provides runtime-independent, elaboration-selected direction prediction in three modes: bimodal, gshare, or tournament (local/global with a choice table).
- Sits beside the BTB/RAS in the frontend: zero-latency lookup on the fetch vPC, non-speculative training from the branch unit on resolution.
- Also exports a saturating mispredict counter for perf counters.

Parameters:
VLEN, 64, virtual PC width
MODE, 2, 0=bimodal, 1=gshare, 2=tournament
GLOBAL_ENTRIES, 1024, global/bimodal counter table depth (power of 2); GHR length = log2(GLOBAL_ENTRIES)
LOCAL_HIST_ENTRIES, 1024, local history table depth (power of 2)
LOCAL_PRED_ENTRIES, 1024, local counter table depth; local history width LHW = log2(LOCAL_PRED_ENTRIES)
CHOICE_ENTRIES, 1024, choice table depth
GLOBAL_CTR_BITS, 2, global counter width (1..4)
LOCAL_CTR_BITS, 2, local counter width (1..4)
CHOICE_CTR_BITS, 2, choice counter width (1..4)
RVC, 1, 1: PC index starts at bit 1; 0: at bit 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_bp_i  in  1  synchronous clear of all tables and history
lookup_valid_i  in  1  fetch lookup request
lookup_pc_i  in  VLEN  fetch vPC
pred_valid_o  out  1  prediction valid
pred_taken_o  out  1  predicted direction
update_valid_i  in  1  resolved conditional branch
update_pc_i  in  VLEN  PC of the resolved branch
update_taken_i  in  1  actual direction
mispredict_cnt_o  out  32  saturating count of mispredicted updates

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values:
  - All counters are weakly not-taken: 2^(N-1)-1.
  - Choice counters are weakly local: 2^(N-1)-1.
  - GHR and all local histories are 0.
  - mispredict_cnt_o is 0; pred_valid_o and pred_taken_o are 0.
- Index derivation: idx(pc) = pc[A+K-1:A], where A = RVC?1:2 and K = log2 of the target table depth.
- Lookup (combinational, 0 cycles):
  - pred_valid_o = lookup_valid_i & ~flush_bp_i.
  - Global index: bimodal uses idx(pc); gshare/tournament use idx(pc) XOR GHR.
  - Local counter index: LHT[idx(pc)].
  - Choice index: idx(pc).
  - A counter predicts taken when its MSB is 1.
  - Tournament: choice MSB=1 selects global, else local.
  - pred_taken_o = pred_valid_o & selected prediction.
- Update (registered, visible to lookups next cycle):
  - On update_valid_i, recompute indices and predictions from the pre-update state, using the same GHR/LHT as lookup.
  - Counters increment toward taken and decrement toward not-taken, saturating at 0 and 2^N-1 with no wrap.
  - Global counter: always trained, in all modes.
  - Local counter and LHT entry: trained in tournament mode only; LHT entry becomes {hist[LHW-2:0], taken}.
  - GHR: shifts in update_taken_i in gshare and tournament modes.
  - Choice counter: trained only when local and global predictions differ; it moves toward whichever was correct.
  - Mispredict: the recomputed final prediction != update_taken_i increments mispredict_cnt_o, saturating at 2^32-1.
- Simultaneous lookup and update to the same entry: the lookup sees the old value; there is no bypass.
- flush_bp_i:
  - Restores all tables and histories to reset values in one cycle.
  - Has priority over a same-cycle update; that update is dropped and is not counted.
  - Does not clear mispredict_cnt_o.
- Unused tables for a given MODE are not generated (generate-guarded).
- Reset asserted mid-operation: all state returns to reset values immediately.

Decomposition:
- Shared package bp_pkg holds:
  - bp_mode_e (BP_BIMODAL, BP_GSHARE, BP_TOURNAMENT).
  - Functions sat_inc/sat_dec(ctr, bits).
  - Function ctr_init(bits) = 2^(bits-1)-1.
- One sub-module, bp_ctr_table:
  - Parameters DEPTH and CTR_BITS.
  - One combinational read port, one write port (valid, index, taken) with saturating update.
  - Synchronous clear input; async active-low reset.
  - Instantiated for the global, local and choice tables.
- LHT and GHR stay in the top level.

Test Plan:
1. Reset, default parameters; lookup pc=0x8000_0000 -> pred_valid_o=1, pred_taken_o=0, mispredict_cnt_o=0.
2. Bimodal; one taken update at pc=0x100 -> next-cycle lookup at 0x100 gives taken, counter=2, mispredict_cnt=1; then 3 more taken and 1 not-taken -> still taken (3->2); a second not-taken -> not-taken (1).
3. Gshare; alternate T/N at pc=0x200 for 40 updates -> the final 10 updates produce 0 additional mispredicts.
4. Tournament; branch with period-3 pattern T,T,N for 60 updates -> choice at idx(pc) saturates local (0) and the last 12 updates add no mispredicts.
5. flush_bp_i with a same-cycle taken update after training to taken -> next lookup is not-taken, GHR=0, mispredict_cnt unchanged by the dropped update.
6. Same-cycle lookup and update to the same index from counter=1 with taken -> that cycle's pred_taken_o=0, next cycle's pred_taken_o=1; then force 2^32 mispredicts (backdoor preload to 0xFFFF_FFFE) -> the counter holds at 0xFFFF_FFFF.
